// File: rtl/interp_pkg.sv
// Shared constants for the HEVC interpolation mux and its sequencer.
// The mux decodes sel against the same round boundaries that the sequencer counts through.
package interp_pkg;

    localparam int unsigned NUM_PIXEL = 8;
    localparam int unsigned SEL_W     = 8;

    localparam int unsigned R1_LEN = 4 * NUM_PIXEL;
    localparam int unsigned R2_LEN = R1_LEN - 5;

    // Each round issues integer rows, then integer columns, then half-B rows.
    localparam int unsigned R1_COL_BASE    = NUM_PIXEL + 8;
    localparam int unsigned R1_HALF_B_BASE = R1_COL_BASE + NUM_PIXEL;
    localparam int unsigned R2_COL_BASE    = NUM_PIXEL + 3;
    localparam int unsigned R2_HALF_B_BASE = R2_COL_BASE + NUM_PIXEL;

    typedef enum logic [1:0] {
        StIdle,
        StR1,
        StR2,
        StDrain
    } state_e;

endpackage

// File: rtl/interp_sel_counter.sv
// Select-code counter for the interpolation sequencer.
// Supports synchronous load-to-zero and count enable, and flags the last code of the round.
module interp_sel_counter
    import interp_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [SEL_W-1:0] round_len,
    output logic [SEL_W-1:0] count,
    output logic             terminal
);

    logic [SEL_W-1:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + SEL_W'(1);
        end
    end

    assign count    = count_q;
    assign terminal = (count_q == round_len - SEL_W'(1));

endmodule

// File: rtl/interp_mux_sequencer.sv
// Sequences the registered row mux of the sub-pixel interpolator through one or two rounds.
// Every issued select produces exactly one mux_valid on the following cycle.
module interp_mux_sequencer
    import interp_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       frac_x,
    input  logic [1:0]       frac_y,
    input  logic             out_ready,
    output logic             busy,
    output logic [SEL_W-1:0] sel,
    output logic             first_round,
    output logic [3:0]       frac_out,
    output logic             mux_valid,
    output logic             mux_last,
    output logic             done
);

    state_e           state_q, state_d;
    logic [3:0]       frac_q, frac_d;
    logic             first_round_q, first_round_d;
    logic             valid_q, last_q, done_q;
    logic             issue, last_d;
    logic             cnt_load, cnt_enable, cnt_terminal;
    logic [SEL_W-1:0] round_len;
    logic             need_r2;

    assign need_r2   = (frac_q[1:0] != 2'd0) && (frac_q[3:2] != 2'd0);
    assign round_len = first_round_q ? SEL_W'(R1_LEN) : SEL_W'(R2_LEN);

    interp_sel_counter u_sel_counter (
        .clock     (clock),
        .reset     (reset),
        .load      (cnt_load),
        .enable    (cnt_enable),
        .round_len (round_len),
        .count     (sel),
        .terminal  (cnt_terminal)
    );

    always_comb begin
        state_d       = state_q;
        frac_d        = frac_q;
        first_round_d = first_round_q;
        issue         = 1'b0;
        last_d        = 1'b0;
        cnt_load      = 1'b0;
        cnt_enable    = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_load      = 1'b1;
                first_round_d = 1'b1;
                if (start) begin
                    frac_d  = {frac_y, frac_x};
                    state_d = StR1;
                end
            end
            StR1: begin
                issue = out_ready;
                if (issue) begin
                    if (!cnt_terminal) begin
                        cnt_enable = 1'b1;
                    end else if (need_r2) begin
                        cnt_load      = 1'b1;
                        first_round_d = 1'b0;
                        state_d       = StR2;
                    end else begin
                        last_d  = 1'b1;
                        state_d = StDrain;
                    end
                end
            end
            StR2: begin
                issue = out_ready;
                if (issue) begin
                    if (!cnt_terminal) begin
                        cnt_enable = 1'b1;
                    end else begin
                        last_d  = 1'b1;
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // The final row is already in the mux register; start is not sampled here.
                cnt_load      = 1'b1;
                first_round_d = 1'b1;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            frac_q        <= 4'd0;
            first_round_q <= 1'b1;
            valid_q       <= 1'b0;
            last_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            frac_q        <= frac_d;
            first_round_q <= first_round_d;
            valid_q       <= issue;
            last_q        <= last_d;
            done_q        <= last_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign first_round = first_round_q;
    assign frac_out    = frac_q;
    assign mux_valid   = valid_q;
    assign mux_last    = last_q;
    assign done        = done_q;

endmodule
